serial_word_tx: RTL and testbench

- Parallel-to-serial stage directly upstream of the 000/111 serial pattern detector.
- Accepts a WIDTH-bit word through a load/ready handshake and shifts it out MSB-first, one bit per clk, on x.
- x feeds the detector's x input.
- Supports gapless back-to-back words, so the detector sees a continuous bit stream.

---
 rtl/serial_word_tx.sv | 120 ++++++++++++
 tb/tb_serial_word_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, MSB first, with gapless back-to-back words.
// Optional even-parity trailer bit enabled by defining SERIAL_WORD_TX_PARITY_EN.
module serial_word_tx #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             last_bit,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef SERIAL_WORD_TX_PARITY_EN
        , PAR
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
`ifdef SERIAL_WORD_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // Outputs decode from registered state only, so load/data_in never reach them.
    always_comb begin
        ready    = 1'b0;
        x        = IDLE_LEVEL;
        x_valid  = 1'b0;
        last_bit = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: ready = 1'b1;
            SHIFT: begin
                x       = shreg_q[WIDTH-1];
                x_valid = 1'b1;
                busy    = 1'b1;
`ifndef SERIAL_WORD_TX_PARITY_EN
                last_bit = (cnt_q == '0);
                ready    = (cnt_q == '0);
`endif
            end
`ifdef SERIAL_WORD_TX_PARITY_EN
            PAR: begin
                x        = par_q;
                x_valid  = 1'b1;
                busy     = 1'b1;
                last_bit = 1'b1;
                ready    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_WORD_TX_PARITY_EN
        par_d   = par_q;
`endif
        accept  = load && ready;
        case (state_q)
            SHIFT: begin
                if (cnt_q != '0) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q - 1'b1;
                end else begin
`ifdef SERIAL_WORD_TX_PARITY_EN
                    state_d = PAR;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef SERIAL_WORD_TX_PARITY_EN
            PAR: state_d = IDLE;
`endif
            default: ;
        endcase
        // Accept only happens when ready, and every ready state hands off to a fresh SHIFT.
        if (accept) begin
            state_d = SHIFT;
            shreg_d = data_in;
            cnt_d   = CW'(WIDTH - 1);
`ifdef SERIAL_WORD_TX_PARITY_EN
            par_d   = ^data_in;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: per-bit scoreboard fed by the driver, popped by a negedge monitor.
module tb_serial_word_tx;
    localparam int W = 8;
`ifdef SERIAL_WORD_TX_PARITY_EN
    localparam bit PAREN = 1'b1;
`else
    localparam bit PAREN = 1'b0;
`endif
    localparam int WLEN = W + int'(PAREN);

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         ready, x, x_valid, last_bit, busy;

    serial_word_tx #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready), .x(x), .x_valid(x_valid), .last_bit(last_bit), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic xb;
        logic last;
        logic rdy;
    } exp_t;

    typedef struct {
        logic [W-1:0] data;
        logic         par;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   passed = 0;
    int   total = 0;
    bit   mon_en = 1'b0;

    task automatic check_b(input string name, input logic got, input logic want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %b expected %b", name, got, want);
    endtask

    task automatic check_i(input string name, input int got, input int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    task automatic push_word(input logic [W-1:0] d, input logic p);
        for (int i = W - 1; i >= 0; i--) begin
            exp_t e;
            e.xb   = d[i];
            e.last = !PAREN && (i == 0);
            e.rdy  = !PAREN && (i == 0);
            exp_q.push_back(e);
        end
        if (PAREN) begin
            exp_t e;
            e.xb = p; e.last = 1'b1; e.rdy = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic p);
        @(posedge clk); #1;
        load = 1'b1; data_in = d;
        push_word(d, p);
        @(posedge clk); #1;
        load = 1'b0; data_in = W'($urandom);
        @(negedge clk);
        check_b("first_bit_latency", x_valid, 1'b1);
        repeat (WLEN + 2) @(posedge clk);
        check_i("drained", exp_q.size(), 0);
    endtask

    // Monitor: every valid bit must match the next scoreboard entry; idle cycles must look idle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (x_valid) begin
                    if (exp_q.size() == 0) check_b("unexpected_bit", x_valid, 1'b0);
                    else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check_b("x", x, e.xb);
                        check_b("last_bit", last_bit, e.last);
                        check_b("ready", ready, e.rdy);
                        check_b("busy", busy, 1'b1);
                    end
                end else begin
                    check_b("idle_x", x, 1'b0);
                    check_b("idle_busy", busy, 1'b0);
                    check_b("idle_ready", ready, 1'b1);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{8'hE3, 1'b1};
        vecs[1] = '{8'h18, 1'b0};
        vecs[2] = '{8'hA5, 1'b0};
        vecs[3] = '{8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b0};
        vecs[5] = '{8'h81, 1'b0};
        vecs[6] = '{8'h01, 1'b1};
        vecs[7] = '{8'h7F, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check_b("rst_x", x, 1'b0);
        check_b("rst_x_valid", x_valid, 1'b0);
        check_b("rst_last_bit", last_bit, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_ready", ready, 1'b1);
        reset = 1'b1;
        mon_en = 1'b1;

        foreach (vecs[i]) send(vecs[i].data, vecs[i].par);

        // Back-to-back: hold load so the second word is taken on the first word's final bit.
        @(posedge clk); #1;
        load = 1'b1; data_in = 8'hE3;
        push_word(8'hE3, 1'b1);
        @(posedge clk); #1;
        data_in = 8'h18;
        push_word(8'h18, 1'b0);
        repeat (WLEN) @(posedge clk);
        #1;
        load = 1'b0; data_in = 8'h55;
        for (int k = 0; k < WLEN; k++) begin
            @(negedge clk);
            check_b("b2b_gapless", x_valid, 1'b1);
        end
        repeat (3) @(posedge clk);
        check_i("b2b_drained", exp_q.size(), 0);

        // Load while busy is ignored.
        @(posedge clk); #1;
        load = 1'b1; data_in = 8'hA5;
        push_word(8'hA5, 1'b0);
        @(posedge clk); #1;
        load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        load = 1'b1; data_in = 8'hFF;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (WLEN + 3) @(posedge clk);
        check_i("ignore_drained", exp_q.size(), 0);

        // Asynchronous reset mid-word discards the rest of the word.
        @(posedge clk); #1;
        load = 1'b1; data_in = 8'hF0;
        push_word(8'hF0, 1'b0);
        @(posedge clk); #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_b("midrst_x", x, 1'b0);
        check_b("midrst_x_valid", x_valid, 1'b0);
        check_b("midrst_busy", busy, 1'b0);
        check_b("midrst_ready", ready, 1'b1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        send(8'h0F, 1'b0);

        // Reset and load on the same edge: reset wins.
        @(posedge clk); #1;
        reset = 1'b0; load = 1'b1; data_in = 8'hFF;
        @(posedge clk); #1;
        reset = 1'b1; load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_b("rst_load_ignored", x_valid, 1'b0);
        check_i("rst_load_queue", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
